// File: rtl/multi_byte_adder_seq_pkg.sv
// ============================================================================
// Module : multi_byte_adder_seq_pkg
// Brief  : Shared constants and state encodings for the byte-serial adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multi_byte_adder_seq_pkg;
   localparam int BYTE_W        = 8;
   localparam int NUM_BYTES_DEF = 4;
   localparam int CNT_W_DEF     = 4;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;
endpackage

`default_nettype wire

// File: rtl/hybrid_adder_circuit.sv
// ============================================================================
// Module : hybrid_adder_circuit
// Brief  : 8-bit adder: bits 1:0 ripple, bits 4:2 carry-lookahead, bits 7:5 ripple.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hybrid_adder_circuit (
   output logic [7:0] S,
   output logic       C8,
   input  logic [7:0] X,
   input  logic [7:0] Y,
   input  logic       C0
);
   logic [7:0] gen;
   logic [7:0] prop;

   assign gen  = X & Y;
   assign prop = X ^ Y;

   always_comb begin
      logic [8:0] carry;
      carry    = '0;
      carry[0] = C0;
      for (int i = 0; i < 2; i++) begin
         carry[i+1] = gen[i] | (prop[i] & carry[i]);
      end
      // Lookahead group: all three carries derive directly from carry[2].
      carry[3] = gen[2] | (prop[2] & carry[2]);
      carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & carry[2]);
      carry[5] = gen[4] | (prop[4] & gen[3]) | (prop[4] & prop[3] & gen[2])
               | (prop[4] & prop[3] & prop[2] & carry[2]);
      for (int i = 5; i < 8; i++) begin
         carry[i+1] = gen[i] | (prop[i] & carry[i]);
      end
      S  = prop ^ carry[7:0];
      C8 = carry[8];
   end
endmodule

`default_nettype wire

// File: rtl/multi_byte_adder_seq.sv
// ============================================================================
// Module : multi_byte_adder_seq
// Brief  : Byte-serial multi-precision adder, LSB first, valid/ready streams.
//          MULTI_BYTE_ADDER_SEQ_OVF_EN enables signed-overflow on the last byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_byte_adder_seq
   import multi_byte_adder_seq_pkg::*;
#(
   parameter int NUM_BYTES = NUM_BYTES_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_x,
   input  logic [BYTE_W-1:0] in_y,
   input  logic              cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] out_sum,
   output logic              out_last,
   output logic              out_cout,
   output logic              out_ovf,
   output logic              busy
);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              carry_q, carry_d;
   logic              out_valid_q, out_valid_d;
   logic [BYTE_W-1:0] out_sum_q, out_sum_d;
   logic              out_last_q, out_last_d;
   logic              out_cout_q, out_cout_d;

   logic              in_xfer;
   logic              out_xfer;
   logic              is_last;
   logic              adder_c0;
   logic              adder_c8;
   logic [BYTE_W-1:0] adder_s;

   assign in_ready = !out_valid_q || out_ready;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid_q && out_ready;
   assign is_last  = (cnt_q == LAST_IDX);
   // Byte 0 always starts from cin; the previous operand's carry never leaks in.
   assign adder_c0 = (cnt_q == '0) ? cin : carry_q;

   hybrid_adder_circuit u_adder (
      .S  (adder_s),
      .C8 (adder_c8),
      .X  (in_x),
      .Y  (in_y),
      .C0 (adder_c0)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (in_xfer) begin
         state_d = is_last ? ST_IDLE : ST_ACCUM;
      end
   end

   always_comb begin
      busy = (state_q == ST_ACCUM);
   end

   always_comb begin
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_last_d  = out_last_q;
      out_cout_d  = out_cout_q;
      if (in_xfer) begin
         cnt_d       = is_last ? '0 : cnt_q + CNT_W'(1);
         carry_d     = adder_c8;
         out_valid_d = 1'b1;
         out_sum_d   = adder_s;
         out_last_d  = is_last;
         out_cout_d  = is_last & adder_c8;
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_last_q  <= 1'b0;
         out_cout_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_last_q  <= out_last_d;
         out_cout_q  <= out_cout_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_last  = out_last_q;
   assign out_cout  = out_cout_q;

`ifdef MULTI_BYTE_ADDER_SEQ_OVF_EN
   logic out_ovf_q, out_ovf_d;

   always_comb begin
      out_ovf_d = out_ovf_q;
      if (in_xfer) begin
         out_ovf_d = is_last && (in_x[BYTE_W-1] == in_y[BYTE_W-1])
                     && (adder_s[BYTE_W-1] != in_x[BYTE_W-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_ovf_q <= 1'b0;
      end else begin
         out_ovf_q <= out_ovf_d;
      end
   end

   assign out_ovf = out_ovf_q;
`else
   assign out_ovf = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_multi_byte_adder_seq.sv
// ============================================================================
// Module : tb_multi_byte_adder_seq
// Brief  : Self-checking bench for 2-byte and 4-byte adder instances.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_byte_adder_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       cin = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] in_x = '0;
   logic [7:0] in_y = '0;
   logic       sel = 1'b0;

`ifdef MULTI_BYTE_ADDER_SEQ_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic       iv2, ir2, ov2, lst2, co2, ovf2, bsy2;
   logic       iv4, ir4, ov4, lst4, co4, ovf4, bsy4;
   logic [7:0] sum2, sum4;

   assign iv2 = in_valid && !sel;
   assign iv4 = in_valid && sel;

   multi_byte_adder_seq #(.NUM_BYTES(2), .CNT_W(4)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_x(in_x), .in_y(in_y),
      .cin(cin), .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2),
      .out_last(lst2), .out_cout(co2), .out_ovf(ovf2), .busy(bsy2)
   );

   multi_byte_adder_seq #(.NUM_BYTES(4), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_x(in_x), .in_y(in_y),
      .cin(cin), .out_valid(ov4), .out_ready(out_ready), .out_sum(sum4),
      .out_last(lst4), .out_cout(co4), .out_ovf(ovf4), .busy(bsy4)
   );

   logic       m_in_ready, m_valid, m_last, m_cout, m_ovf, m_busy;
   logic [7:0] m_sum;
   assign m_in_ready = sel ? ir4  : ir2;
   assign m_valid    = sel ? ov4  : ov2;
   assign m_last     = sel ? lst4 : lst2;
   assign m_cout     = sel ? co4  : co2;
   assign m_ovf      = sel ? ovf4 : ovf2;
   assign m_busy     = sel ? bsy4 : bsy2;
   assign m_sum      = sel ? sum4 : sum2;

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] sum;
      logic       last;
      logic       cout;
      logic       ovf;
   } exp_t;

   typedef struct {
      int          nb;
      logic [31:0] x;
      logic [31:0] y;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Scoreboard: every output handshake pops and checks one expected byte.
   always @(negedge clk) begin
      exp_t e;
      if (m_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out got sum=%h last=%b", m_sum, m_last);
         end else begin
            e = sb.pop_front();
            if ({m_sum, m_last, m_cout, m_ovf} !== {e.sum, e.last, e.cout, e.ovf}) begin
               bad++;
               $display("FAIL out_byte got sum=%h last=%b cout=%b ovf=%b want sum=%h last=%b cout=%b ovf=%b",
                        m_sum, m_last, m_cout, m_ovf, e.sum, e.last, e.cout, e.ovf);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic xfer(input logic [7:0] x, input logic [7:0] y, input logic c,
                       input exp_t e, input bit want_no_stall);
      int n = 0;
      in_valid = 1'b1;
      in_x     = x;
      in_y     = y;
      cin      = c;
      @(negedge clk);
      while (!m_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (want_no_stall) chk("no_bubble", 32'(n), 32'd0);
      if (!m_in_ready) begin
         total++;
         bad++;
         $display("FAIL in_ready_timeout got=0 want=1");
      end else begin
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // cin is driven inverted on bytes 1.. to show it is ignored there.
   task automatic send_operand(input int nb, input logic [31:0] x, input logic [31:0] y,
                               input logic c, input logic [31:0] s, input logic co,
                               input logic ov);
      for (int i = 0; i < nb; i++) begin
         exp_t e;
         e.sum  = s[8*i +: 8];
         e.last = (i == nb - 1);
         e.cout = e.last ? co : 1'b0;
         e.ovf  = (e.last && OVF_ON) ? ov : 1'b0;
         xfer(x[8*i +: 8], y[8*i +: 8], (i == 0) ? c : ~c, e, 1'b1);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout got=%0d want=0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[7];
      exp_t        e;
      logic [31:0] rx, ry;
      logic        rc;
      logic [32:0] full;

      tbl[0] = '{2, 32'h0000_60FF, 32'h0000_7F01, 1'b0, 32'h0000_E000, 1'b0, 1'b1};
      tbl[1] = '{2, 32'h0000_FFFF, 32'h0000_FFFE, 1'b0, 32'h0000_FFFD, 1'b1, 1'b0};
      tbl[2] = '{2, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
      tbl[3] = '{2, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
      tbl[4] = '{4, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
      tbl[5] = '{4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[6] = '{4, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid2", 32'(ov2), 32'd0);
      chk("rst_out_valid4", 32'(ov4), 32'd0);
      chk("rst_in_ready2", 32'(ir2), 32'd1);
      chk("rst_busy4", 32'(bsy4), 32'd0);
      chk("rst_fields2", {22'd0, sum2, lst2, co2}, 32'd0);
      chk("rst_ovf4", 32'(ovf4), 32'd0);
      @(posedge clk);
      #1;

      // Table vectors: same-width entries run back to back, no idle cycles.
      for (int i = 0; i < 7; i++) begin
         if (sel != (tbl[i].nb == 4)) begin
            drain();
            sel = (tbl[i].nb == 4);
         end
         send_operand(tbl[i].nb, tbl[i].x, tbl[i].y, tbl[i].cin,
                      tbl[i].sum, tbl[i].cout, tbl[i].ovf);
      end
      drain();

      // Random 4-byte operands against integer arithmetic.
      for (int k = 0; k < 6; k++) begin
         rx   = $urandom;
         ry   = $urandom;
         rc   = 1'($urandom_range(0, 1));
         full = {1'b0, rx} + {1'b0, ry} + 33'(rc);
         send_operand(4, rx, ry, rc, full[31:0], full[32],
                      (rx[31] == ry[31]) && (full[31] != rx[31]));
      end
      drain();

      // Backpressure on the 2-byte instance.
      sel = 1'b0;
      e = '{8'hFF, 1'b0, 1'b0, 1'b0};
      xfer(8'hAA, 8'h55, 1'b0, e, 1'b1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_x      = 8'h08;
      in_y      = 8'h81;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(m_in_ready), 32'd0);
         chk("bp_hold_sum", {24'd0, m_sum}, 32'h0000_00FF);
         chk("bp_hold_valid", 32'(m_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      e = '{8'h89, 1'b1, 1'b0, 1'b0};
      xfer(8'h08, 8'h81, 1'b1, e, 1'b0);
      drain();

      // Reset mid-operand on the 4-byte instance.
      sel = 1'b1;
      e = '{8'h00, 1'b0, 1'b0, 1'b0};
      xfer(8'hFF, 8'h01, 1'b0, e, 1'b1);
      xfer(8'hFF, 8'h00, 1'b1, e, 1'b1);
      chk("mid_busy", 32'(m_busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(m_valid), 32'd0);
      chk("mid_rst_busy", 32'(m_busy), 32'd0);
      chk("mid_rst_fields", {21'd0, m_sum, m_last, m_cout, m_ovf}, 32'd0);
      chk("mid_rst_sb_empty", 32'(sb.size()), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      send_operand(4, 32'h0000_00F0, 32'h0000_0088, 1'b0, 32'h0000_0078 + 32'h0000_0100,
                   1'b0, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
